// File: rtl/fetch_word_splitter_pkg.sv
// Shared widths and state encoding for the fetch word splitter.
// Imported by the splitter and by anything that wants to decode its state.
package fetch_word_splitter_pkg;

    localparam int WORD_W_DEF  = 64;
    localparam int INSTR_W_DEF = 32;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_LOW  = 2'd2,
        ST_HIGH = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_word_splitter.sv
// Splits 64-bit fetch FIFO words into two 32-bit instructions, low half
// first, over a valid/ready handshake, bypassing the FIFO read latency.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   fifo_empty          FIFO buf_empty
//   fifo_data           FIFO buf_out, valid the cycle after a sampled read
//   fifo_rd_en          FIFO rd_en (combinational)
//   flush, flush_odd    redirect; flush_odd drops the low half of next word
//   out_valid/ready     handshake to decode
//   out_instr/out_half  instruction and which half it came from
//   issued_cnt          count of accepted instructions (wrapping)
module fetch_word_splitter
    import fetch_word_splitter_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fifo_empty,
    input  logic [WORD_W-1:0]  fifo_data,
    output logic               fifo_rd_en,
    input  logic               flush,
    input  logic               flush_odd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic               out_half,
    output logic [CNT_W-1:0]   issued_cnt
);

    state_t              state;
    logic [WORD_W-1:0]   hold;
    logic                skip;
    logic                take;

    // rd_en is gated by rst_n so a FIFO that is non-empty during reset is
    // never popped while the splitter is held in reset.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (rst_n && !flush && !fifo_empty) begin
            unique case (state)
                ST_IDLE: fifo_rd_en = 1'b1;
                ST_HIGH: fifo_rd_en = out_ready;
                ST_FILL: fifo_rd_en = skip && out_ready;
                ST_LOW:  fifo_rd_en = 1'b0;
            endcase
        end
    end

    // In FILL the instruction comes straight from fifo_data (bypass).
    always_comb begin
        out_instr = '0;
        out_half  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                out_instr = '0;
                out_half  = 1'b0;
            end
            ST_FILL: begin
                out_half  = skip;
                out_instr = skip ? fifo_data[WORD_W-1:INSTR_W]
                                 : fifo_data[INSTR_W-1:0];
            end
            ST_LOW: begin
                out_instr = hold[INSTR_W-1:0];
                out_half  = 1'b0;
            end
            ST_HIGH: begin
                out_instr = hold[WORD_W-1:INSTR_W];
                out_half  = 1'b1;
            end
        endcase
    end

    assign out_valid = !flush && (state != ST_IDLE);
    assign take      = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hold       <= '0;
            skip       <= 1'b0;
            issued_cnt <= '0;
        end else begin
            if (take)
                issued_cnt <= issued_cnt + CNT_W'(1);

            if (flush) begin
                state <= ST_IDLE;
                skip  <= flush_odd;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (fifo_rd_en)
                            state <= ST_FILL;
                    end
                    ST_FILL: begin
                        hold <= fifo_data;
                        if (skip) begin
                            // The odd-slot restart is consumed by this word
                            // whether or not decode takes it now.
                            skip <= 1'b0;
                            if (out_ready)
                                state <= fifo_rd_en ? ST_FILL : ST_IDLE;
                            else
                                state <= ST_HIGH;
                        end else begin
                            state <= out_ready ? ST_HIGH : ST_LOW;
                        end
                    end
                    ST_LOW: begin
                        if (out_ready)
                            state <= ST_HIGH;
                    end
                    ST_HIGH: begin
                        if (out_ready)
                            state <= fifo_rd_en ? ST_FILL : ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_word_splitter.sv
// Scoreboard bench for fetch_word_splitter with a one-cycle-latency FIFO
// model; expected instructions are queued as words are pushed.
module tb_fetch_word_splitter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic [63:0] fifo_data;
    logic        fifo_rd_en;
    logic        flush;
    logic        flush_odd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_half;
    logic [15:0] issued_cnt;

    fetch_word_splitter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .flush_odd  (flush_odd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_half   (out_half),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] W1 = 64'h22222222_11111111;
    localparam logic [63:0] W2 = 64'h66666666_55555555;
    localparam logic [63:0] W3 = 64'h44444444_33333333;

    logic [63:0] fq[$];
    logic [32:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic push_word(input logic [63:0] w, input bit odd);
        fq.push_back(w);
        fifo_empty <= 1'b0;
        if (!odd)
            exp_q.push_back({1'b0, w[31:0]});
        exp_q.push_back({1'b1, w[63:32]});
    endtask

    task automatic fifo_model();
        while (!done) begin
            @(posedge clk);
            if (fifo_rd_en) begin
                if (fq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_on_empty: got rd_en 1 expected 0");
                end else begin
                    fifo_data  <= fq.pop_front();
                    fifo_empty <= (fq.size() == 0);
                end
            end
        end
    endtask

    task automatic monitor();
        logic [32:0] e;
        while (!done) begin
            @(negedge clk);
            #2;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected: got %h expected none",
                             out_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr", 64'(out_instr), 64'(e[31:0]));
                    chk("half", 64'(out_half), 64'(e[32]));
                end
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic stimulus();
        int n;
        // reset values, asynchronously
        #1;
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_rd", 64'(fifo_rd_en), 0);
        chk("rst_cnt", 64'(issued_cnt), 0);
        chk("rst_instr", 64'(out_instr), 0);
        chk("rst_half", 64'(out_half), 0);
        cyc(); rst_n = 1'b1;
        cyc();

        // single word
        cyc(); push_word(W1, 1'b0); #2;
        chk("t1_rd_c0", 64'(fifo_rd_en), 1);
        chk("t1_valid_c0", 64'(out_valid), 0);
        cyc(); #2;
        chk("t1_valid_c1", 64'(out_valid), 1);
        chk("t1_rd_c1", 64'(fifo_rd_en), 0);
        cyc(); #2;
        chk("t1_valid_c2", 64'(out_valid), 1);
        chk("t1_rd_c2", 64'(fifo_rd_en), 0);
        cyc(); #2;
        chk("t1_valid_c3", 64'(out_valid), 0);
        chk("t1_cnt", 64'(issued_cnt), 2);

        // two words streaming
        cyc(); push_word(W1, 1'b0); push_word(W2, 1'b0); #2;
        chk("t2_rd_c0", 64'(fifo_rd_en), 1);
        cyc(); #2;
        chk("t2_valid_c1", 64'(out_valid), 1);
        chk("t2_rd_c1", 64'(fifo_rd_en), 0);
        cyc(); #2;
        chk("t2_valid_c2", 64'(out_valid), 1);
        chk("t2_rd_c2", 64'(fifo_rd_en), 1);
        cyc(); #2;
        chk("t2_valid_c3", 64'(out_valid), 1);
        chk("t2_rd_c3", 64'(fifo_rd_en), 0);
        cyc(); #2;
        chk("t2_valid_c4", 64'(out_valid), 1);
        cyc(); #2;
        chk("t2_valid_c5", 64'(out_valid), 0);
        chk("t2_cnt", 64'(issued_cnt), 6);

        // backpressure during FILL
        cyc(); out_ready = 1'b0; push_word(W1, 1'b0); #2;
        chk("t3_rd_c0", 64'(fifo_rd_en), 1);
        cyc(); #2;
        chk("t3_instr_c1", 64'(out_instr), 64'h11111111);
        chk("t3_rd_c1", 64'(fifo_rd_en), 0);
        cyc(); #2;
        chk("t3_valid_c2", 64'(out_valid), 1);
        chk("t3_instr_c2", 64'(out_instr), 64'h11111111);
        chk("t3_half_c2", 64'(out_half), 0);
        chk("t3_rd_c2", 64'(fifo_rd_en), 0);
        cyc(); out_ready = 1'b1;
        cyc();
        cyc(); #2;
        chk("t3_valid_end", 64'(out_valid), 0);
        chk("t3_cnt", 64'(issued_cnt), 8);

        // flush with odd restart while in HIGH
        cyc(); push_word(W1, 1'b0);
        cyc();
        cyc(); flush = 1'b1; flush_odd = 1'b1; exp_q.delete(); #2;
        chk("t4_valid_flush", 64'(out_valid), 0);
        chk("t4_rd_flush", 64'(fifo_rd_en), 0);
        cyc(); flush = 1'b0; flush_odd = 1'b0; push_word(W3, 1'b1); #2;
        chk("t4_rd", 64'(fifo_rd_en), 1);
        cyc(); #2;
        chk("t4_half", 64'(out_half), 1);
        cyc(); #2;
        chk("t4_valid_end", 64'(out_valid), 0);
        chk("t4_cnt", 64'(issued_cnt), 10);

        // reset mid-stream
        cyc(); push_word(W1, 1'b0); push_word(W2, 1'b0);
        cyc();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 64'(out_valid), 0);
        chk("t5_rd", 64'(fifo_rd_en), 0);
        chk("t5_cnt", 64'(issued_cnt), 0);
        fq.delete();
        exp_q.delete();
        fifo_empty <= 1'b1;
        cyc(); rst_n = 1'b1; #2;
        chk("t5_valid_after", 64'(out_valid), 0);

        // stream to counter wrap
        cyc();
        for (int i = 0; i < 32768; i++)
            push_word({32'(i) + 32'h5000_0000, 32'(i)}, 1'b0);
        n = 0;
        while (issued_cnt != 16'hFFFF && n < 70000) begin
            cyc(); #2;
            n++;
        end
        chk("t6_cnt_max", 64'(issued_cnt), 64'hFFFF);
        chk("t6_valid_last", 64'(out_valid), 1);
        cyc(); #2;
        chk("t6_cnt_wrap", 64'(issued_cnt), 0);
        chk("t6_valid_end", 64'(out_valid), 0);
        cyc();
        done = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        flush      = 1'b0;
        flush_odd  = 1'b0;
        out_ready  = 1'b1;
        fork
            fifo_model();
            monitor();
            stimulus();
        join
        chk("drain", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
